epp_img_loader: RTL and testbench
=================================

# epp_img_loader

Host-side ingest stage ahead of the SIFT pipeline: an EPP (IEEE 1284 enhanced parallel port) slave that decodes host address and data cycles and exposes a small register file. It turns a host byte stream of one IMG_W×IMG_H greyscale frame into an addressed pixel stream with valid/ready backpressure. On frame completion it raises EPP_Interrupt. `sift_top` owns the EPP_Data tristate buffer; this block sees the bus as split in/out/oe signals.

## Interface
- IMG_W, 512, pixels per line
- IMG_H, 512, lines per frame
- ADDR_W, 18, pixel address width, ≥ clog2(IMG_W*IMG_H)
- clk_sys  in  1  system clock; the only clock
- rst_sys  in  1  synchronous, active-high reset
- EPP_Write  in  1  async, low = host write, high = host read
- EPP_DataStrobe  in  1  async, active-low data-cycle strobe
- EPP_AddressStrobe  in  1  async, active-low address-cycle strobe
- EPP_Reset  in  1  async, active-low host soft reset
- epp_data_i  in  8  EPP_Data as driven by host
- epp_data_o  out  8  read-back data
- epp_data_oe  out  1  top drives EPP_Data = epp_data_o when 1
- EPP_Wait  out  1  cycle acknowledge to host
- EPP_Interrupt  out  1  frame-complete interrupt, level
- pix_data  out  8  pixel value
- pix_addr  out  ADDR_W  raster address, y*IMG_W + x
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel

## Operation
- Four async inputs pass through 2-flop synchronizers. The FSM uses only synchronized values. EPP_Reset low (synced) acts exactly like rst_sys.
- Registers, selected by addr_reg, which is written by address-write cycles and read back by address-read cycles:
  - 0x00 CTRL (W): bit0 = 1 arms load, clears pix counter, clears INT, clears DROP.
  - 0x01 STATUS (R): bit0 LOADING, bit1 DONE, bit2 DROP, bit3 PERR. Reading it clears DONE, PERR and EPP_Interrupt.
  - 0x02 PIXEL (W): each data write is one pixel.
  - Other addresses: writes ignored; reads return 0x00.
- FSM states and transitions:
  - IDLE: waits for exactly one synced strobe low.
  - EXEC: samples epp_data_i on entry; performs the register access. For a read, sets oe=1 and latches epp_data_o.
  - PUSH: PIXEL write with LOADING=1 only. Holds pix_valid=1 until pix_ready.
  - ACK: EPP_Wait=1 until the synced strobe returns high.
  - Then back to IDLE with EPP_Wait=0 and oe=0.
- PIXEL write while LOADING=0: acknowledged, byte dropped, DROP set.
- Counter reaches IMG_W*IMG_H-1 and that pixel is accepted: LOADING=0, DONE=1, EPP_Interrupt=1, counter returns to 0.
- Both strobes low in IDLE: protocol error. PERR set, no ACK; the FSM stays in IDLE until both are high.

## Timing
- Reset values: EPP_Wait 0, EPP_Interrupt 0, epp_data_oe 0, epp_data_o 0x00, pix_valid 0, pix_data 0, pix_addr 0, addr_reg 0x00, all status bits 0.
- Strobe edge to EPP_Wait rise:
  - Non-pixel cycles: 4 clk_sys edges (2 sync + EXEC + ACK).
  - Pixel cycles: 4 edges plus the number of cycles pix_ready is held low.
- Strobe release to EPP_Wait fall: 3 clk_sys edges. epp_data_oe falls on the same edge.
- pix_valid, pix_data and pix_addr are registered. They are stable while pix_valid=1 and not pix_ready. pix_valid drops the cycle after the handshake.
- Throughput: at most one pixel per EPP cycle, and at most one pixel every 7 clocks.
- Reset mid-cycle:
  - pix_valid drops immediately and any pending pixel is lost.
  - EPP_Wait drops, and the host times out.
- A CTRL arm during LOADING restarts the counter at 0.

## Structure
- Package epp_pkg holds:
  - Register addresses (REG_CTRL, REG_STATUS, REG_PIXEL)
  - STATUS bit indices
  - FSM state enum (IDLE, EXEC, PUSH, ACK)
- Sub-module epp_sync: a generic 2-flop synchronizer with width parameter, instantiated once for the 4-bit strobe/control group.

## Test plan
- Reset, then address-write 0x00, data-write 0x01, address-write 0x02, then 4 data writes 0x11..0x14 with pix_ready=1. Expect pixels (0,0x11)…(3,0x14), then address-read returns 0x02.
- Same sequence with pix_ready low for 20 cycles on the 2nd pixel. Expect EPP_Wait for that cycle delayed by exactly 20 clocks, pix_data held at 0x12, and no loss.
- Run a full frame with IMG_W=IMG_H=4: 16 writes. Expect pix_addr 0..15 and EPP_Interrupt rising after the 16th accept. STATUS read returns 0x02 and EPP_Interrupt drops; a second STATUS read returns 0x00.
- PIXEL write without arming. Expect EPP_Wait handshake, no pix_valid, and STATUS read returns 0x04.
- Both strobes low together. Expect no EPP_Wait; after release, STATUS returns 0x08.
- Assert EPP_Reset low while pix_valid=1 and pix_ready=0. Expect pix_valid=0, EPP_Wait=0 and STATUS=0x00 within 3 clocks of the sync delay.

Source files
------------

// File: rtl/epp_pkg.sv
// Shared definitions for the EPP image loader: register map,
// STATUS bit positions and the bus-cycle FSM state encoding.
package epp_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_PIXEL  = 8'h02;

    localparam int ST_LOADING = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_DROP    = 2;
    localparam int ST_PERR    = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        PUSH,
        ACK
    } epp_state_t;

endpackage

// File: rtl/epp_sync.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Flops reset to RST_VAL so inputs look inactive straight out of reset.
module epp_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/epp_img_loader.sv
// EPP slave: decodes host address/data cycles into a small register
// file and turns PIXEL writes into an addressed valid/ready stream.
module epp_img_loader
    import epp_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              EPP_Write,
    input  logic              EPP_DataStrobe,
    input  logic              EPP_AddressStrobe,
    input  logic              EPP_Reset,
    input  logic [7:0]        epp_data_i,
    output logic [7:0]        epp_data_o,
    output logic              epp_data_oe,
    output logic              EPP_Wait,
    output logic              EPP_Interrupt,
    output logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

    logic [3:0]        w_sync;
    logic              w_ds;
    logic              w_as;
    logic              w_wr;
    logic              w_rst;
    logic              w_one_low;
    logic              w_both_low;
    logic              w_both_high;
    logic              w_start;
    logic              w_pix_go;
    logic              w_accept;
    logic              w_cyc_high;
    logic [7:0]        w_status;
    epp_state_t        w_next;

    epp_state_t        r_state;
    logic [7:0]        r_addr_reg;
    logic [7:0]        r_data;
    logic              r_is_addr;
    logic              r_is_rd;
    logic              r_blk;
    logic              r_loading;
    logic              r_done;
    logic              r_drop;
    logic              r_perr;
    logic              r_int;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wait;
    logic              r_oe;
    logic [7:0]        r_dout;
    logic              r_pvalid;
    logic [7:0]        r_pdata;
    logic [ADDR_W-1:0] r_paddr;

    epp_sync #(
        .W       (4),
        .RST_VAL (4'b1111)
    ) u_sync (
        .i_clk (clk_sys),
        .i_rst (rst_sys),
        .i_d   ({EPP_Reset, EPP_Write, EPP_AddressStrobe, EPP_DataStrobe}),
        .o_q   (w_sync)
    );

    assign w_ds        = w_sync[0];
    assign w_as        = w_sync[1];
    assign w_wr        = w_sync[2];
    assign w_rst       = rst_sys | ~w_sync[3];
    assign w_one_low   = w_ds ^ w_as;
    assign w_both_low  = ~w_ds & ~w_as;
    assign w_both_high = w_ds & w_as;
    assign w_start     = (r_state == IDLE) && w_one_low && !r_blk;
    assign w_pix_go    = w_start && !w_ds && !w_wr &&
                         (r_addr_reg == REG_PIXEL) && r_loading;
    assign w_accept    = r_pvalid && pix_ready &&
                         ((r_state == EXEC) || (r_state == PUSH));
    assign w_cyc_high  = r_is_addr ? w_as : w_ds;

    always_comb begin
        w_status             = '0;
        w_status[ST_LOADING] = r_loading;
        w_status[ST_DONE]    = r_done;
        w_status[ST_DROP]    = r_drop;
        w_status[ST_PERR]    = r_perr;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_start) w_next = EXEC;
            EXEC: w_next = (!r_pvalid || pix_ready) ? ACK : PUSH;
            PUSH: if (pix_ready) w_next = ACK;
            ACK:  if (w_cyc_high) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_addr_reg <= '0;
            r_data     <= '0;
            r_is_addr  <= 1'b0;
            r_is_rd    <= 1'b0;
            r_blk      <= 1'b0;
            r_loading  <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
            r_perr     <= 1'b0;
            r_int      <= 1'b0;
            r_cnt      <= '0;
            r_wait     <= 1'b0;
            r_oe       <= 1'b0;
            r_dout     <= '0;
            r_pvalid   <= 1'b0;
            r_pdata    <= '0;
            r_paddr    <= '0;
        end else begin
            r_wait <= (w_next == ACK);
            // Both strobes low is illegal; stay blocked until both release.
            if ((r_state == IDLE) && w_both_low) begin
                r_blk  <= 1'b1;
                r_perr <= 1'b1;
            end else if (w_both_high) begin
                r_blk <= 1'b0;
            end
            if (w_start) begin
                r_data    <= epp_data_i;
                r_is_addr <= ~w_as;
                r_is_rd   <= w_wr;
            end
            if (w_pix_go) begin
                r_pvalid <= 1'b1;
                r_pdata  <= epp_data_i;
                r_paddr  <= r_cnt;
            end
            if (r_state == EXEC) begin
                if (r_is_rd) begin
                    r_oe <= 1'b1;
                    if (r_is_addr) begin
                        r_dout <= r_addr_reg;
                    end else if (r_addr_reg == REG_STATUS) begin
                        r_dout <= w_status;
                        r_done <= 1'b0;
                        r_perr <= 1'b0;
                        r_int  <= 1'b0;
                    end else begin
                        r_dout <= '0;
                    end
                end else if (r_is_addr) begin
                    r_addr_reg <= r_data;
                end else if ((r_addr_reg == REG_CTRL) && r_data[0]) begin
                    r_loading <= 1'b1;
                    r_cnt     <= '0;
                    r_int     <= 1'b0;
                    r_drop    <= 1'b0;
                end else if ((r_addr_reg == REG_PIXEL) && !r_pvalid) begin
                    r_drop <= 1'b1;
                end
            end
            if (w_accept) begin
                r_pvalid <= 1'b0;
                if (r_cnt == LAST_PIX) begin
                    r_cnt     <= '0;
                    r_loading <= 1'b0;
                    r_done    <= 1'b1;
                    r_int     <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                end
            end
            if ((r_state == ACK) && (w_next == IDLE)) r_oe <= 1'b0;
        end
    end

    assign epp_data_o    = r_dout;
    assign epp_data_oe   = r_oe;
    assign EPP_Wait      = r_wait;
    assign EPP_Interrupt = r_int;
    assign pix_data      = r_pdata;
    assign pix_addr      = r_paddr;
    assign pix_valid     = r_pvalid;

endmodule

// File: tb/tb_epp_img_loader.sv
// Scoreboard bench for epp_img_loader on a 4x4 frame: host tasks
// queue expectations, a negedge monitor checks pixels and read-backs.
module tb_epp_img_loader;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_sys;
    logic          EPP_Write = 1'b1;
    logic          EPP_DataStrobe = 1'b1;
    logic          EPP_AddressStrobe = 1'b1;
    logic          EPP_Reset = 1'b1;
    logic [7:0]    epp_data_i = 8'h00;
    logic [7:0]    epp_data_o;
    logic          epp_data_oe;
    logic          EPP_Wait;
    logic          EPP_Interrupt;
    logic [7:0]    pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_valid;
    logic          pix_ready = 1'b1;

    epp_img_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk_sys           (clk),
        .rst_sys           (rst_sys),
        .EPP_Write         (EPP_Write),
        .EPP_DataStrobe    (EPP_DataStrobe),
        .EPP_AddressStrobe (EPP_AddressStrobe),
        .EPP_Reset         (EPP_Reset),
        .epp_data_i        (epp_data_i),
        .epp_data_o        (epp_data_o),
        .epp_data_oe       (epp_data_oe),
        .EPP_Wait          (EPP_Wait),
        .EPP_Interrupt     (EPP_Interrupt),
        .pix_data          (pix_data),
        .pix_addr          (pix_addr),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  rd_q[$];

    // reference model of the host-visible register state
    logic [7:0] m_addr = 8'h00;
    bit m_load, m_done, m_drop, m_perr, m_int;
    int m_cnt;

    int stall_left = 0;
    bit hold_ready = 0;
    bit rand_ready = 0;
    bit stab_skip = 0;
    int valid_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (hold_ready) pix_ready = 1'b0;
        else if (pix_valid === 1'b1 && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
        else pix_ready = 1'b1;
    end

    bit prev_v = 0, prev_r = 0, prev_w = 0;
    logic [7:0]    prev_d;
    logic [AW-1:0] prev_a;
    logic [15:0]   e;

    always @(negedge clk) begin
        if (pix_valid === 1'b1) valid_seen++;
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            if (sb_q.size() == 0) chk("pix_unexpected", 1, 0);
            else begin
                e = sb_q.pop_front();
                chk("pix_addr", 32'(pix_addr), 32'(e[15:8]));
                chk("pix_data", 32'(pix_data), 32'(e[7:0]));
            end
        end
        if (!stab_skip && prev_v && !prev_r) begin
            chk("hold_valid", 32'(pix_valid), 1);
            chk("hold_data", 32'(pix_data), 32'(prev_d));
            chk("hold_addr", 32'(pix_addr), 32'(prev_a));
        end
        if (EPP_Wait === 1'b1 && !prev_w && epp_data_oe === 1'b1) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", 32'(epp_data_o), 32'(rd_q.pop_front()));
        end
        prev_v = (pix_valid === 1'b1);
        prev_r = (pix_ready === 1'b1);
        prev_w = (EPP_Wait === 1'b1);
        prev_d = pix_data;
        prev_a = pix_addr;
    end

    task automatic epp_cycle(input bit is_addr, input bit is_rd,
                             input logic [7:0] wd, input int exp_lat);
        int lat;
        bit seen;
        @(posedge clk); #1;
        EPP_Write = is_rd;
        if (!is_rd) epp_data_i = wd;
        if (is_addr) EPP_AddressStrobe = 1'b0;
        else EPP_DataStrobe = 1'b0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            seen = (EPP_Wait === 1'b1);
        end
        chk("wait_rise", 32'(seen), 1);
        if (exp_lat >= 0) chk("wait_rise_lat", lat, exp_lat);
        if (is_rd) chk("oe_on_read", 32'(epp_data_oe), 1);
        EPP_AddressStrobe = 1'b1;
        EPP_DataStrobe = 1'b1;
        lat = 0;
        while (seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            seen = (EPP_Wait === 1'b1);
        end
        chk("wait_fall_lat", lat, 3);
        chk("oe_fall", 32'(epp_data_oe), 0);
        EPP_Write = 1'b1;
    endtask

    task automatic addr_wr(input logic [7:0] v);
        m_addr = v;
        epp_cycle(1, 0, v, 4);
    endtask

    task automatic addr_rd();
        rd_q.push_back(m_addr);
        epp_cycle(1, 1, 8'h00, 4);
    endtask

    task automatic data_wr(input logic [7:0] v, input int lat);
        if (m_addr == 8'h00 && v[0]) begin
            m_load = 1; m_cnt = 0; m_int = 0; m_drop = 0;
        end else if (m_addr == 8'h02) begin
            if (m_load) begin
                sb_q.push_back({8'(m_cnt), v});
                m_cnt++;
                if (m_cnt == NPIX) begin
                    m_cnt = 0; m_load = 0; m_done = 1; m_int = 1;
                end
            end else m_drop = 1;
        end
        epp_cycle(0, 0, v, lat);
        chk("irq_after_wr", 32'(EPP_Interrupt), 32'(m_int));
    endtask

    task automatic data_rd();
        logic [7:0] exp;
        exp = 8'h00;
        if (m_addr == 8'h01) begin
            exp = {4'b0, m_perr, m_drop, m_done, m_load};
            m_done = 0; m_perr = 0; m_int = 0;
        end
        rd_q.push_back(exp);
        epp_cycle(0, 1, 8'h00, 4);
        chk("irq_after_rd", 32'(EPP_Interrupt), 32'(m_int));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit any_wait;
        int v0;
        rst_sys = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_wait", 32'(EPP_Wait), 0);
        chk("rst_irq", 32'(EPP_Interrupt), 0);
        chk("rst_oe", 32'(epp_data_oe), 0);
        chk("rst_dout", 32'(epp_data_o), 0);
        chk("rst_pvalid", 32'(pix_valid), 0);
        chk("rst_pdata", 32'(pix_data), 0);
        chk("rst_paddr", 32'(pix_addr), 0);
        rst_sys = 1'b0;
        repeat (3) @(posedge clk);

        // protocol error: both strobes at once
        addr_wr(8'h01);
        @(posedge clk); #1;
        EPP_AddressStrobe = 1'b0;
        EPP_DataStrobe = 1'b0;
        any_wait = 0;
        repeat (10) begin
            @(posedge clk); #1;
            any_wait |= (EPP_Wait === 1'b1);
        end
        chk("perr_no_wait", 32'(any_wait), 0);
        EPP_AddressStrobe = 1'b1;
        EPP_DataStrobe = 1'b1;
        m_perr = 1;
        repeat (5) @(posedge clk);
        data_rd();
        data_rd();

        // basic load of four pixels
        addr_wr(8'h00);
        data_wr(8'h01, 4);
        addr_wr(8'h02);
        for (int i = 0; i < 4; i++) data_wr(8'(8'h11 + i), 4);
        addr_rd();

        // re-arm while loading, stall the second pixel by 20 clocks
        addr_wr(8'h00);
        data_wr(8'h01, 4);
        addr_wr(8'h02);
        data_wr(8'h11, 4);
        stall_left = 20;
        data_wr(8'h12, 24);
        data_wr(8'h13, 4);
        data_wr(8'h14, 4);

        // full frame, random data and random backpressure
        rand_ready = 1;
        addr_wr(8'h00);
        data_wr(8'h01, 4);
        addr_wr(8'h02);
        for (int i = 0; i < NPIX; i++) data_wr(8'($urandom), -1);
        rand_ready = 0;
        addr_wr(8'h01);
        data_rd();
        data_rd();

        // pixel write without arming is dropped
        addr_wr(8'h02);
        v0 = valid_seen;
        data_wr(8'hAA, 4);
        chk("drop_no_valid", valid_seen, v0);
        addr_wr(8'h01);
        data_rd();

        // host reset while a pixel is stalled
        addr_wr(8'h00);
        data_wr(8'h01, 4);
        addr_wr(8'h02);
        hold_ready = 1;
        @(posedge clk); #1;
        EPP_Write = 1'b0;
        epp_data_i = 8'h5A;
        EPP_DataStrobe = 1'b0;
        k = 0;
        while (pix_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_pv_up", 32'(pix_valid), 1);
        stab_skip = 1;
        EPP_Reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("erst_pvalid", 32'(pix_valid), 0);
        chk("erst_wait", 32'(EPP_Wait), 0);
        chk("erst_irq", 32'(EPP_Interrupt), 0);
        EPP_DataStrobe = 1'b1;
        EPP_Write = 1'b1;
        repeat (4) @(posedge clk);
        EPP_Reset = 1'b1;
        repeat (4) @(posedge clk);
        hold_ready = 0;
        repeat (2) @(posedge clk);
        stab_skip = 0;
        m_addr = 8'h00;
        m_load = 0; m_done = 0; m_drop = 0; m_perr = 0; m_int = 0;
        m_cnt = 0;
        addr_wr(8'h01);
        data_rd();

        repeat (5) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        chk("rd_empty", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
